serial_addsub: RTL
==================

Name: serial_addsub

Overview:
- Parametrised, digit-serial add/subtract unit; multi-cycle successor to the single-bit combinational full subtractor.
- Processes WIDTH-bit operands DIGIT bits per clock, LSB first, through a chain of 1-bit add/sub cells, with a registered borrow/carry between digits.
- Start/busy/done handshake; returns result, borrow/carry-out and signed overflow.
- Sits in the arithmetic datapath wherever a small-area subtractor is preferred to a full-width ripple.

Parameters:
- WIDTH, 8, operand/result width in bits.
- DIGIT, 1, bits processed per cycle. Must divide WIDTH exactly; elaboration fails otherwise. N = WIDTH/DIGIT cycles per operation.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only while busy=0.
- mode  input  1  0 = subtract (a-b-bin), 1 = add (a+b+bin).
- a  input  WIDTH  minuend/augend; sampled at the accepting edge.
- b  input  WIDTH  subtrahend/addend; sampled at the accepting edge.
- bin  input  1  borrow-in (sub) or carry-in (add); sampled at the accepting edge.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; result valid.
- result  output  WIDTH  difference/sum.
- bout  output  1  borrow-out (sub) or carry-out (add).
- ovf  output  1  two's-complement overflow.

Behaviour:
- Reset (async assert, sync release): state IDLE; busy, done, result, bout and ovf are 0; internal registers cleared. Assertion mid-operation aborts the operation, and no done is issued.
- State IDLE, accepting edge (start=1, busy=0):
  - Latch a, b, mode and bin.
  - Digit counter cnt=0; go to RUN; busy=1 after the edge.
- State RUN, each edge processes digit cnt, bits [cnt*DIGIT +: DIGIT]:
  - Sub cell: d=x^y^z; bw=~x&z | ~x&y | y&z.
  - Add cell: s=x^y^z; c=x&y | x&z | y&z.
  - The chain inside a digit is combinational ripple. The inter-digit borrow/carry is registered.
  - Digit results are shifted into an internal accumulator. Outputs result, bout and ovf do not change during RUN.
- Completion, edge with cnt==N-1:
  - result, bout and ovf are updated.
  - done=1 for exactly one cycle; busy=0; state IDLE.
- Overflow: ovf = (borrow/carry into bit WIDTH-1) XOR (borrow/carry out of bit WIDTH-1). This gives a-b-bin overflow in sub mode and a+b+bin overflow in add mode.
- Latency: done is visible after the N-th edge following the accepting edge. Throughput is one operation per N cycles.
- Back-to-back: start may be accepted in the done cycle (busy=0). The new operation begins and done drops the next cycle. Earlier outputs hold until the new completion.
- start while busy=1: ignored. Changes to a, b, mode or bin during RUN have no effect.
- Outputs hold indefinitely in IDLE until the next completion.
- WIDTH=DIGIT (N=1): accept, then done after one edge. Behaviour is otherwise identical.

Decomposition:
- Shared package arith_pkg holds:
  - state enum {IDLE, RUN}.
  - mode constants MODE_SUB=1'b0, MODE_ADD=1'b1.
  - helper function clog2 for sizing cnt as max(1, clog2(N)).
- Sub-module addsub_cell: 1-bit cell with inputs x, y, z, mode and outputs r, co. serial_addsub instantiates DIGIT copies in a generate chain.

Test Plan:
- Reset: hold rst_n=0, start=1 -> busy=0, done=0, result=0x00, bout=0, ovf=0; then assert rst_n=0 mid-RUN -> all outputs 0 immediately, no done.
- WIDTH=8, DIGIT=1, sub 0x05-0x03, bin=0 -> result=0x02, bout=0, ovf=0. done high exactly 8 edges after the accepting edge, one cycle wide.
- Sub 0x03-0x05, bin=0 -> 0xFE, bout=1, ovf=0. Sub 0x80-0x01 -> 0x7F, bout=0, ovf=1. Sub 0x00-0x00, bin=1 -> 0xFF, bout=1, ovf=0.
- Add 0xFF+0x01, bin=0 -> 0x00, bout=1, ovf=0. Add 0x7F+0x01 -> 0x80, bout=0, ovf=1.
- Handshake: pulse start again at cycle 3 of RUN with different operands -> ignored, first result unchanged. start held high during done -> second operation accepted, done again 8 edges later.
- WIDTH=8, DIGIT=4, sub 0x80-0x01 -> done after 2 edges, result=0x7F, ovf=1. Exhaustive random compare against a-b-bin and a+b+bin reference for 1000 operations.

Source files
------------

// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared types, mode constants and sizing helper for serial arithmetic
package arith_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic MODE_SUB = 1'b0;
    localparam logic MODE_ADD = 1'b1;

    // Ceiling log2; returns 0 for v <= 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/addsub_cell.sv
// rtl/addsub_cell.sv - 1-bit full adder / full subtractor cell
import arith_pkg::*;

module addsub_cell (
    input  logic x,
    input  logic y,
    input  logic z,
    input  logic mode,
    output logic r,
    output logic co
);

    logic w_carry;
    logic w_borrow;

    // Sum and difference share the same XOR; only the carry/borrow term differs.
    assign r        = x ^ y ^ z;
    assign w_carry  = (x & y) | (x & z) | (y & z);
    assign w_borrow = (~x & z) | (~x & y) | (y & z);
    assign co       = (mode == MODE_ADD) ? w_carry : w_borrow;

endmodule

// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - digit-serial add/subtract unit with start/busy/done handshake
import arith_pkg::*;

module serial_addsub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             bout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (clog2(N) < 1) ? 1 : clog2(N);

    generate
        if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
            $error("serial_addsub: DIGIT must divide WIDTH exactly");
        end
    endgenerate

    state_t           r_state;
    state_t           w_next_state;
    logic             w_accept;
    logic             w_last;

    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic             r_mode;
    logic             r_cy;
    logic [WIDTH-1:0] r_result;
    logic             r_bout;
    logic             r_ovf;
    logic             r_done;

    logic [DIGIT:0]   w_c;
    logic [DIGIT-1:0] w_digit;
    logic [WIDTH-1:0] w_acc_next;

    // Operands are shifted right each cycle, so the current digit is always at the bottom.
    assign w_c[0] = r_cy;

    genvar gi;
    generate
        for (gi = 0; gi < DIGIT; gi++) begin : g_cell
            addsub_cell u_cell (
                .x    (r_a[gi]),
                .y    (r_b[gi]),
                .z    (w_c[gi]),
                .mode (r_mode),
                .r    (w_digit[gi]),
                .co   (w_c[gi+1])
            );
        end

        // Results enter at the top of the accumulator so the LSB digit ends up at bit 0.
        if (N == 1) begin : g_acc_single
            assign w_acc_next = w_digit;
        end else begin : g_acc_shift
            assign w_acc_next = {w_digit, r_acc[WIDTH-1:DIGIT]};
        end
    endgenerate

    // Next-state logic: accept in IDLE, finish on the last digit.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_next_state = RUN;
                end
            end
            RUN: begin
                if (r_cnt == CW'(N - 1)) begin
                    w_last       = 1'b1;
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Datapath: latch operands, step one digit per cycle, publish outputs on the last digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_mode   <= MODE_SUB;
            r_cy     <= 1'b0;
            r_result <= '0;
            r_bout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_a    <= a;
                r_b    <= b;
                r_mode <= mode;
                r_cy   <= bin;
                r_cnt  <= '0;
                r_acc  <= '0;
            end else if (r_state == RUN) begin
                r_a   <= r_a >> DIGIT;
                r_b   <= r_b >> DIGIT;
                r_cy  <= w_c[DIGIT];
                r_acc <= w_acc_next;
                r_cnt <= r_cnt + CW'(1);
                if (w_last) begin
                    r_result <= w_acc_next;
                    r_bout   <= w_c[DIGIT];
                    r_ovf    <= w_c[DIGIT-1] ^ w_c[DIGIT];
                    r_done   <= 1'b1;
                end
            end
        end
    end

    assign busy   = (r_state == RUN);
    assign done   = r_done;
    assign result = r_result;
    assign bout   = r_bout;
    assign ovf    = r_ovf;

endmodule
